// File: rtl/axi_id_remap_table.sv
// AXI4 ID remapper: folds a wide slave ID space onto 2**MstIdWidth master IDs through
// per-direction tracking tables, restoring the original ID on B and R.
package axi_id_remap_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } slv_aw_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } mst_aw_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } slv_ar_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } mst_ar_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } slv_b_t;
  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
  } mst_b_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } slv_r_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } mst_r_t;
  typedef struct packed {
    slv_aw_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    slv_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } slv_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    slv_b_t b;
    logic   b_valid;
    slv_r_t r;
    logic   r_valid;
  } slv_resp_t;
  typedef struct packed {
    mst_aw_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    mst_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mst_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    mst_b_t b;
    logic   b_valid;
    mst_r_t r;
    logic   r_valid;
  } mst_resp_t;
endpackage

// Protocol checks for one remap table.
module axi_id_remap_tbl_chk #(
  parameter int unsigned MstIdWidth = 2,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned CntWidth   = 4,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input logic                  clk,
  input logic                  rst,
  input logic [NumEntries-1:0] in_use,
  input logic [CntWidth-1:0]   cnt [NumEntries],
  input logic                  push,
  input logic [MstIdWidth-1:0] idx,
  input logic                  pop,
  input logic                  rsp_valid,
  input logic [MstIdWidth-1:0] rsp_id,
  input logic                  req_valid,
  input logic                  req_illegal
);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

  rsp_on_free_entry: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> in_use[rsp_id]);
  cnt_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !(pop && (rsp_id == idx))) |-> (cnt[idx] != MaxCnt));
  cnt_underflow: assert property (@(posedge clk) disable iff (rst)
    pop |-> (cnt[rsp_id] != '0));
  atop_with_r_rsp: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> !req_illegal);
endmodule

// One ID table: lookup/allocation on the request side, release on the response side.
module axi_id_remap_tbl #(
  parameter int unsigned SlvIdWidth   = 8,
  parameter int unsigned MstIdWidth   = 2,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [SlvIdWidth-1:0] req_id,
  input  logic                  req_ready,
  input  logic                  req_illegal,
  input  logic                  rsp_valid,
  input  logic                  rsp_ready,
  input  logic                  rsp_last,
  input  logic [MstIdWidth-1:0] rsp_id,
  output logic                  stall,
  output logic [MstIdWidth-1:0] mst_id,
  output logic [SlvIdWidth-1:0] slv_id,
  output logic                  busy
);
  localparam int unsigned NumEntries = 2**MstIdWidth;
  localparam int unsigned CntWidth   = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

  logic [NumEntries-1:0] in_use_r;
  logic [SlvIdWidth-1:0] slv_id_r [NumEntries];
  logic [CntWidth-1:0]   cnt_r    [NumEntries];
  logic                  hold_valid_r;
  logic [MstIdWidth-1:0] hold_idx_r;

  logic [NumEntries-1:0] hit_vec_s, free_vec_s, inc_vec_s, dec_vec_s;
  logic [MstIdWidth-1:0] hit_idx_s, free_idx_s, idx_s;
  logic                  stall_s, fwd_s, push_s, pop_s;

  function automatic logic [MstIdWidth-1:0] lowest_set(input logic [NumEntries-1:0] vec);
    logic [MstIdWidth-1:0] idx;
    idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      idx = vec[i] ? MstIdWidth'(i) : idx;
    end
    return idx;
  endfunction

  // Per-entry hit/free flags and their lowest-index encodings.
  always_comb begin
    hit_vec_s  = '0;
    free_vec_s = '0;
    for (int i = 0; i < NumEntries; i++) begin
      hit_vec_s[i]  = in_use_r[i] && (slv_id_r[i] == req_id);
      free_vec_s[i] = !in_use_r[i];
    end
    hit_idx_s  = lowest_set(hit_vec_s);
    free_idx_s = lowest_set(free_vec_s);
  end

  // Index selection: a held index wins, then a hit, then the lowest free entry.
  always_comb begin
    idx_s   = free_idx_s;
    stall_s = ~(|free_vec_s);
    if (hold_valid_r) begin
      idx_s   = hold_idx_r;
      stall_s = 1'b0;
    end else if (|hit_vec_s) begin
      idx_s   = hit_idx_s;
      stall_s = (cnt_r[hit_idx_s] == MaxCnt);
    end else begin
      idx_s   = free_idx_s;
      stall_s = ~(|free_vec_s);
    end
  end

  assign fwd_s  = req_valid && !stall_s;
  assign push_s = fwd_s && req_ready;
  assign pop_s  = rsp_valid && rsp_ready && rsp_last;

  // Per-entry increment/decrement strobes.
  always_comb begin
    inc_vec_s = '0;
    dec_vec_s = '0;
    for (int i = 0; i < NumEntries; i++) begin
      inc_vec_s[i] = push_s && (idx_s == MstIdWidth'(i));
      dec_vec_s[i] = pop_s && (rsp_id == MstIdWidth'(i));
    end
  end

  // Hold register keeps the forwarded ID stable across a back-pressured request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_idx_r   <= '0;
    end else if (push_s) begin
      hold_valid_r <= 1'b0;
    end else if (fwd_s) begin
      hold_valid_r <= 1'b1;
      hold_idx_r   <= idx_s;
    end
  end

  // Table entries; a simultaneous allocate and release leaves the count as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use_r <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        slv_id_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        case ({inc_vec_s[i], dec_vec_s[i]})
          2'b10: begin
            if (cnt_r[i] != MaxCnt) begin
              cnt_r[i]    <= cnt_r[i] + CntWidth'(1);
              in_use_r[i] <= 1'b1;
              slv_id_r[i] <= req_id;
            end
          end
          2'b01: begin
            if (cnt_r[i] != '0) begin
              cnt_r[i]    <= cnt_r[i] - CntWidth'(1);
              in_use_r[i] <= (cnt_r[i] != CntWidth'(1));
            end
          end
          2'b11: begin
            in_use_r[i] <= 1'b1;
            slv_id_r[i] <= req_id;
          end
          default: ;
        endcase
      end
    end
  end

  assign stall  = stall_s;
  assign mst_id = idx_s;
  assign slv_id = slv_id_r[rsp_id];
  assign busy   = |in_use_r;

  axi_id_remap_tbl_chk #(
    .MstIdWidth   (MstIdWidth),
    .NumEntries   (NumEntries),
    .CntWidth     (CntWidth),
    .MaxTxnsPerId (MaxTxnsPerId)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .in_use      (in_use_r),
    .cnt         (cnt_r),
    .push        (push_s),
    .idx         (idx_s),
    .pop         (pop_s),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .req_valid   (req_valid),
    .req_illegal (req_illegal)
  );
endmodule

module axi_id_remap_table #(
  parameter int unsigned SlvIdWidth   = 8,
  parameter int unsigned MstIdWidth   = 2,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter type slv_req_t  = axi_id_remap_pkg::slv_req_t,
  parameter type slv_resp_t = axi_id_remap_pkg::slv_resp_t,
  parameter type mst_req_t  = axi_id_remap_pkg::mst_req_t,
  parameter type mst_resp_t = axi_id_remap_pkg::mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i,
  output logic      wr_busy_o,
  output logic      rd_busy_o
);
  logic                  wr_stall_s, rd_stall_s, run_s;
  logic [MstIdWidth-1:0] wr_mst_id_s, rd_mst_id_s;
  logic [SlvIdWidth-1:0] wr_slv_id_s, rd_slv_id_s;

  assign run_s = !rst_i;

  axi_id_remap_tbl #(
    .SlvIdWidth (SlvIdWidth), .MstIdWidth (MstIdWidth), .MaxTxnsPerId (MaxTxnsPerId)
  ) u_wr_tbl (
    .clk         (clk_i),
    .rst         (rst_i),
    .req_valid   (slv_req_i.aw_valid),
    .req_id      (slv_req_i.aw.id),
    .req_ready   (mst_resp_i.aw_ready),
    .req_illegal (slv_req_i.aw.atop[5]),
    .rsp_valid   (mst_resp_i.b_valid),
    .rsp_ready   (slv_req_i.b_ready),
    .rsp_last    (1'b1),
    .rsp_id      (mst_resp_i.b.id),
    .stall       (wr_stall_s),
    .mst_id      (wr_mst_id_s),
    .slv_id      (wr_slv_id_s),
    .busy        (wr_busy_o)
  );

  axi_id_remap_tbl #(
    .SlvIdWidth (SlvIdWidth), .MstIdWidth (MstIdWidth), .MaxTxnsPerId (MaxTxnsPerId)
  ) u_rd_tbl (
    .clk         (clk_i),
    .rst         (rst_i),
    .req_valid   (slv_req_i.ar_valid),
    .req_id      (slv_req_i.ar.id),
    .req_ready   (mst_resp_i.ar_ready),
    .req_illegal (1'b0),
    .rsp_valid   (mst_resp_i.r_valid),
    .rsp_ready   (slv_req_i.r_ready),
    .rsp_last    (mst_resp_i.r.last),
    .rsp_id      (mst_resp_i.r.id),
    .stall       (rd_stall_s),
    .mst_id      (rd_mst_id_s),
    .slv_id      (rd_slv_id_s),
    .busy        (rd_busy_o)
  );

  // Channel forwarding with ID substitution; handshakes are forced low while in reset.
  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;

    mst_req_o.aw.id    = wr_mst_id_s;
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.atop  = slv_req_i.aw.atop;
    mst_req_o.aw_valid = run_s && slv_req_i.aw_valid && !wr_stall_s;
    slv_resp_o.aw_ready = run_s && mst_resp_i.aw_ready && !wr_stall_s;

    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = run_s && slv_req_i.w_valid;
    slv_resp_o.w_ready = run_s && mst_resp_i.w_ready;

    slv_resp_o.b.id    = wr_slv_id_s;
    slv_resp_o.b.resp  = mst_resp_i.b.resp;
    slv_resp_o.b_valid = run_s && mst_resp_i.b_valid;
    mst_req_o.b_ready  = run_s && slv_req_i.b_ready;

    mst_req_o.ar.id    = rd_mst_id_s;
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar_valid = run_s && slv_req_i.ar_valid && !rd_stall_s;
    slv_resp_o.ar_ready = run_s && mst_resp_i.ar_ready && !rd_stall_s;

    slv_resp_o.r.id    = rd_slv_id_s;
    slv_resp_o.r.data  = mst_resp_i.r.data;
    slv_resp_o.r.resp  = mst_resp_i.r.resp;
    slv_resp_o.r.last  = mst_resp_i.r.last;
    slv_resp_o.r_valid = run_s && mst_resp_i.r_valid;
    mst_req_o.r_ready  = run_s && slv_req_i.r_ready;
  end
endmodule
